// File: rtl/ps2_scancode_receiver_if.sv
// CPU-side bus of the PS/2 scancode receiver: event FIFO head, pop strobe,
// last released key and the error/overflow pulses.
interface ps2_scancode_receiver_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Handshake: valid is high while the FIFO holds an entry and the head sits
    // on code/code_ext/code_break. A cycle with rd_en=1 and valid=1 consumes
    // the head at the next clock edge; rd_en with valid=0 has no effect. The
    // head never changes while valid=1 unless it is consumed.
    logic          rd_en;
    logic [7:0]    code;
    logic          code_ext;
    logic          code_break;
    logic          valid;
    logic [CW-1:0] fifo_count;
    logic [7:0]    last_key;
    logic          overflow;
    logic          parity_err;
    logic          frame_err;

    modport master (
        input  rd_en,
        output code, code_ext, code_break, valid, fifo_count,
        output last_key, overflow, parity_err, frame_err
    );

    modport slave (
        output rd_en,
        input  code, code_ext, code_break, valid, fifo_count,
        input  last_key, overflow, parity_err, frame_err
    );
endinterface

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: pin synchronisers and deglitch filters, 11-bit frame
// deframer with parity/stop checks and a watchdog, E0/F0 prefix decoder and a
// first-word fall-through event FIFO towards the CPU.
module ps2_scancode_receiver #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000,
    parameter int FIFO_DEPTH  = 8,
    parameter int DECODE_MODE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ps2_clk,
    input  logic                    ps2_data,
    ps2_scancode_receiver_if.master bus,
    output logic [1:0]              fsm_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          clk_filt, data_filt, clk_prev;
    logic [FW-1:0] clk_cnt, data_cnt;
    logic          fall;

    state_t        state, state_nx;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [WW-1:0] wd_cnt;
    logic          timeout;
    logic          perr_c, ferr_c, good_c;

    logic          byte_done;
    logic [7:0]    byte_q;
    logic          parity_err_q, frame_err_q;
    logic          ext, brk;
    logic [7:0]    last_key_q;
    logic          push_req;
    logic [9:0]    push_data;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, push, pop, overflow_q;

    // Two-flop synchronisers; the idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Deglitch: a filtered pin follows only after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_filt  <= 1'b1;
            data_filt <= 1'b1;
            clk_cnt   <= '0;
            data_cnt  <= '0;
            clk_prev  <= 1'b1;
        end else begin
            clk_prev <= clk_filt;
            if (clk_s2 == clk_filt) begin
                clk_cnt <= '0;
            end else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                clk_cnt  <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            if (data_s2 == data_filt) begin
                data_cnt <= '0;
            end else if (data_cnt == FW'(FILTER_LEN - 1)) begin
                data_filt <= data_s2;
                data_cnt  <= '0;
            end else begin
                data_cnt <= data_cnt + 1'b1;
            end
        end
    end

    assign fall    = clk_prev & ~clk_filt;
    // A falling edge in the same cycle keeps the frame alive.
    assign timeout = (state != IDLE) && !fall && (wd_cnt == WW'(TIMEOUT_CYC - 1));

    // Deframer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Deframer next state and frame verdicts.
    always_comb begin
        state_nx = state;
        perr_c   = 1'b0;
        ferr_c   = 1'b0;
        good_c   = 1'b0;
        if (timeout) begin
            state_nx = IDLE;
            ferr_c   = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_filt) state_nx = DATA;
                    else            ferr_c   = 1'b1;
                end
                DATA:   if (bitcnt == 3'd7) state_nx = PARITY;
                PARITY: state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    perr_c   = ~(^shreg ^ par_bit);
                    ferr_c   = ~data_filt;
                    good_c   = (^shreg ^ par_bit) & data_filt;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Deframer datapath, watchdog and registered verdict strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitcnt       <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            wd_cnt       <= '0;
            byte_done    <= 1'b0;
            byte_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (state == IDLE || fall) wd_cnt <= '0;
            else                       wd_cnt <= wd_cnt + 1'b1;
            if (timeout) begin
                shreg  <= '0;
                bitcnt <= '0;
            end else if (fall) begin
                case (state)
                    IDLE:   bitcnt  <= '0;
                    DATA: begin
                        shreg  <= {data_filt, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                    end
                    PARITY: par_bit <= data_filt;
                    default: ;
                endcase
            end
            parity_err_q <= perr_c;
            frame_err_q  <= ferr_c;
            byte_done    <= good_c;
            if (good_c) byte_q <= shreg;
        end
    end

    assign push_req  = byte_done &&
                       ((DECODE_MODE == 0) || (byte_q != 8'hE0 && byte_q != 8'hF0));
    assign push_data = (DECODE_MODE != 0) ? {ext, brk, byte_q} : {2'b00, byte_q};

    // Prefix flags and last released key; any frame error drops pending prefixes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            last_key_q <= '0;
        end else if (parity_err_q || frame_err_q) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_done && DECODE_MODE != 0) begin
            if (byte_q == 8'hE0) begin
                ext <= 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (brk) last_key_q <= byte_q;
            end
        end
    end

    assign full = (count == CW'(FIFO_DEPTH));
    assign pop  = bus.rd_en && (count != '0);
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign push = push_req && (!full || pop);

    // Event FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            overflow_q <= push_req && full && !pop;
        end
    end

    assign bus.code       = mem[rd_ptr][7:0];
    assign bus.code_break = mem[rd_ptr][8];
    assign bus.code_ext   = mem[rd_ptr][9];
    assign bus.valid      = (count != '0);
    assign bus.fifo_count = count;
    assign bus.last_key   = last_key_q;
    assign bus.overflow   = overflow_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign fsm_state      = state;
endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Bench for ps2_scancode_receiver: directed PS/2 frames, expected FIFO entries
// queued at stimulus time and checked by an independent head monitor.
module tb_ps2_scancode_receiver;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 300;
    localparam int FIFO_DEPTH  = 8;
    localparam int HALF        = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [1:0] fsm_state;

    ps2_scancode_receiver_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus_if ();

    ps2_scancode_receiver #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DECODE_MODE(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus_if.master),
        .fsm_state(fsm_state)
    );

    logic [9:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int n_perr = 0;
    int n_ferr = 0;
    int n_ovf = 0;
    bit auto_read = 1'b0;
    bit manual_pop = 1'b0;
    event stop_fall_ev;

    // Clock
    always #5 clk = ~clk;

    // Overall time limit
    initial begin
        #900us;
        $display("FAIL global_timeout: got no end expected finish");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reader: drives rd_en away from the active edge
    initial begin
        bus_if.rd_en = 1'b0;
        forever begin
            @(negedge clk);
            bus_if.rd_en = (auto_read && bus_if.valid) || manual_pop;
            manual_pop   = 1'b0;
        end
    end

    // Monitor: pulse counters and scoreboard compare on each accepted head
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (bus_if.parity_err) n_perr++;
                if (bus_if.frame_err)  n_ferr++;
                if (bus_if.overflow)   n_ovf++;
                if (bus_if.rd_en && bus_if.valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_entry: got %0h expected none",
                                 {bus_if.code_ext, bus_if.code_break, bus_if.code});
                    end else begin
                        e = exp_q.pop_front();
                        check("fifo_head", {bus_if.code_ext, bus_if.code_break, bus_if.code}, e);
                    end
                end
            end
        end
    end

    // One PS/2 bit; optional short low glitch on ps2_clk during the high phase
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (4) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - 9) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop_b, input bit glitch);
        logic [9:0] bits;
        bits = {(~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(bits[i], glitch && i >= 1 && i <= 8);
        ps2_data = stop_b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        -> stop_fall_ev;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic drain();
        auto_read = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || bus_if.valid); i++) @(negedge clk);
        check("drain_queue_left", exp_q.size(), 0);
        check("drain_fifo_count", bus_if.fifo_count, 0);
        auto_read = 1'b0;
        @(negedge clk);
    endtask

    // Directed sequence
    initial begin
        int p0, f0, o0;
        logic [7:0] codes [9];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

        repeat (5) @(negedge clk);
        check("rst_valid", bus_if.valid, 0);
        check("rst_count", bus_if.fifo_count, 0);
        check("rst_head", {bus_if.code_ext, bus_if.code_break, bus_if.code}, 0);
        check("rst_pulses", {bus_if.overflow, bus_if.parity_err, bus_if.frame_err}, 0);
        check("rst_last_key", bus_if.last_key, 0);
        check("rst_state", fsm_state, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single make code
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("make_valid", bus_if.valid, 1);
        check("make_count", bus_if.fifo_count, 1);
        check("make_head", {bus_if.code_ext, bus_if.code_break, bus_if.code}, {2'b00, 8'h1C});
        drain();

        // Break and extended break
        exp_q.push_back({2'b01, 8'h1C});
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("break_count", bus_if.fifo_count, 1);
        check("break_last_key", bus_if.last_key, 8'h1C);
        exp_q.push_back({2'b11, 8'h75});
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1, 1'b0);
        check("ext_break_count", bus_if.fifo_count, 2);
        check("ext_break_last_key", bus_if.last_key, 8'h75);
        drain();

        // Parity error after E0 drops the pending prefix
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        p0 = n_perr;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        check("parity_err_pulses", n_perr - p0, 1);
        check("parity_no_push", bus_if.fifo_count, 0);
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        drain();

        // Stop bit error after F0
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        f0 = n_ferr;
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        check("stop_frame_err_pulses", n_ferr - f0, 1);
        check("stop_no_push", bus_if.fifo_count, 0);
        exp_q.push_back({2'b00, 8'h33});
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        check("stop_last_key_kept", bus_if.last_key, 8'h75);
        drain();

        // Watchdog: start + 3 data bits, then silence
        f0 = n_ferr;
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        repeat (200) @(negedge clk);
        check("wd_not_yet", n_ferr - f0, 0);
        check("wd_state_busy", fsm_state, 1);
        repeat (150) @(negedge clk);
        check("wd_frame_err", n_ferr - f0, 1);
        check("wd_state_idle", fsm_state, 0);
        check("wd_no_push", bus_if.fifo_count, 0);
        exp_q.push_back({2'b00, 8'h2A});
        send_frame(8'h2A, 1'b0, 1'b1, 1'b0);
        drain();

        // Overflow: FIFO_DEPTH+1 make codes, no reads
        o0 = n_ovf;
        for (int i = 0; i < 9; i++) begin
            if (i < FIFO_DEPTH) exp_q.push_back({2'b00, codes[i]});
            send_frame(codes[i], 1'b0, 1'b1, 1'b0);
        end
        check("ovf_count", bus_if.fifo_count, FIFO_DEPTH);
        check("ovf_pulses", n_ovf - o0, 1);
        drain();

        // Full FIFO, push coinciding with a pop
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            exp_q.push_back({2'b00, codes[i]});
            send_frame(codes[i], 1'b0, 1'b1, 1'b0);
        end
        check("full_count", bus_if.fifo_count, FIFO_DEPTH);
        o0 = n_ovf;
        exp_q.push_back({2'b00, 8'h4D});
        fork
            send_frame(8'h4D, 1'b0, 1'b1, 1'b0);
            begin
                @(stop_fall_ev);
                repeat (10) @(negedge clk);
                #2 manual_pop = 1'b1;
            end
        join
        check("full_pop_no_ovf", n_ovf - o0, 0);
        check("full_pop_count", bus_if.fifo_count, FIFO_DEPTH);
        drain();

        // Short ps2_clk glitches inside the data bits
        f0 = n_ferr;
        exp_q.push_back({2'b00, 8'h4B});
        send_frame(8'h4B, 1'b0, 1'b1, 1'b1);
        check("glitch_no_err", n_ferr - f0, 0);
        drain();

        // Reset mid-frame with FIFO data and a stored last_key
        exp_q.push_back({2'b00, 8'h16});
        send_frame(8'h16, 1'b0, 1'b1, 1'b0);
        exp_q.push_back({2'b01, 8'h5A});
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check("pre_rst_last_key", bus_if.last_key, 8'h5A);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("mid_rst_valid", bus_if.valid, 0);
        check("mid_rst_count", bus_if.fifo_count, 0);
        check("mid_rst_last_key", bus_if.last_key, 0);
        check("mid_rst_state", fsm_state, 0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        exp_q.push_back({2'b00, 8'h29});
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        check("post_rst_count", bus_if.fifo_count, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
